// File: rtl/cpu_common_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_common_pkg
//  Purpose  : Shared types for the CPU front-end blocks. Holds the skid
//             buffer state encoding used by fifo_skid_reader.
//  Revision : 1.0  initial release
// ============================================================================
package cpu_common_pkg;

  // Encoding equals the number of buffered entries, so the state can drive
  // an occupancy count directly.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

endpackage
`default_nettype wire

// File: rtl/fifo_skid_reader_if.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_skid_reader_if
//  Purpose  : Upstream FIFO read port plus downstream valid/ready channel of
//             the skid reader. 'slave' is the reader side, 'master' is the
//             environment that owns the FIFO and the consumer.
//  Revision : 1.0  initial release
// ============================================================================
interface fifo_skid_reader_if #(
  parameter int DATA_WIDTH = 16
) ();

  logic [DATA_WIDTH-1:0] fifo_rdata_i;
  logic                  fifo_empty_i;
  logic                  fifo_rready_o;
  logic                  flush_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  valid_o;
  logic                  ready_i;
  logic [1:0]            occupancy_o;

  modport slave (
    input  fifo_rdata_i, fifo_empty_i, flush_i, ready_i,
    output fifo_rready_o, data_o, valid_o, occupancy_o
  );

  modport master (
    output fifo_rdata_i, fifo_empty_i, flush_i, ready_i,
    input  fifo_rready_o, data_o, valid_o, occupancy_o
  );

endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Purpose  : Up counter that sticks at its all-ones value. Synchronous
//             active-high reset clears it.
//  Revision : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Count enabled events, stopping once every bit is set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fifo_skid_reader.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_skid_reader
//  Purpose  : Two-entry skid buffer that pops a zero-latency upstream FIFO and
//             presents entries on a valid/ready channel. The pop request never
//             depends on the downstream ready, breaking that timing path.
//  Options  : FIFO_SKID_READER_STATS_EN adds stall_cycles_o, a saturating count
//             of cycles with valid_o high and ready_i low.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_skid_reader
  import cpu_common_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
`ifdef FIFO_SKID_READER_STATS_EN
  output logic [15:0]       stall_cycles_o,
`endif
  fifo_skid_reader_if.slave bus
);

  skid_state_e           r_state;
  skid_state_e           w_next_state;
  logic [DATA_WIDTH-1:0] r_main;
  logic [DATA_WIDTH-1:0] r_skid;
  logic [DATA_WIDTH-1:0] w_main_nxt;
  logic [DATA_WIDTH-1:0] w_skid_nxt;
  logic                  w_pop;
  logic                  w_valid;
  logic                  w_xfer;

  // Pop only from buffer fullness and upstream/flush/reset, never ready_i.
  assign w_pop   = ~reset & ~bus.fifo_empty_i & ~bus.flush_i & (r_state != SKID_FULL);
  assign w_valid = (r_state != SKID_EMPTY);
  assign w_xfer  = w_valid & bus.ready_i;

  // Next-state and data movement between main and skid registers.
  always_comb begin
    w_next_state = r_state;
    w_main_nxt   = r_main;
    w_skid_nxt   = r_skid;
    case (r_state)
      SKID_EMPTY: begin
        if (w_pop) begin
          w_next_state = SKID_ONE;
          w_main_nxt   = bus.fifo_rdata_i;
        end
      end
      SKID_ONE: begin
        if (w_pop && w_xfer) begin
          w_main_nxt = bus.fifo_rdata_i;
        end else if (w_pop) begin
          w_next_state = SKID_FULL;
          w_skid_nxt   = bus.fifo_rdata_i;
        end else if (w_xfer) begin
          w_next_state = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (w_xfer) begin
          w_next_state = SKID_ONE;
          w_main_nxt   = r_skid;
        end
      end
      default: begin
        w_next_state = SKID_EMPTY;
      end
    endcase
    // Flush discards everything; data registers keep their contents so
    // data_o holds its last value while invalid.
    if (bus.flush_i) begin
      w_next_state = SKID_EMPTY;
      w_main_nxt   = r_main;
      w_skid_nxt   = r_skid;
    end
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SKID_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_next_state;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  assign bus.fifo_rready_o = w_pop;
  assign bus.data_o        = r_main;
  assign bus.valid_o       = w_valid;
  assign bus.occupancy_o   = r_state;

`ifdef FIFO_SKID_READER_STATS_EN
  logic w_stall;

  assign w_stall = w_valid & ~bus.ready_i;

  sat_counter #(
    .WIDTH (16)
  ) u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_stall),
    .o_count (stall_cycles_o)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_skid_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_skid_reader
//  Purpose  : Self-checking bench for fifo_skid_reader. A queue of buffered
//             entries acts as the reference; directed scenarios plus a random
//             run are compared against it and against fixed expectations.
//  Options  : FIFO_SKID_READER_STATS_EN enables the stall counter scenario.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_skid_reader;

  localparam int c_RAND_CYCLES = 400;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  // Reference: ordered list of entries held by the reader, and the value
  // data_o must keep once the list is empty.
  logic [15:0] mq[$];
  logic [15:0] mlast;
  logic        m_pop;
  logic        m_xfer;

  fifo_skid_reader_if #(.DATA_WIDTH(16)) bus ();

`ifdef FIFO_SKID_READER_STATS_EN
  logic [15:0] stall_cycles;
`endif

  fifo_skid_reader #(
    .DATA_WIDTH (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
`ifdef FIFO_SKID_READER_STATS_EN
    .stall_cycles_o (stall_cycles),
`endif
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic m_rready();
    return !reset && !bus.fifo_empty_i && !bus.flush_i && (mq.size() < 2);
  endfunction

  function automatic logic [15:0] m_data();
    return (mq.size() > 0) ? mq[0] : mlast;
  endfunction

  // Apply inputs after the falling edge, then let outputs settle.
  task automatic drive(input logic rs, input logic e, input logic [15:0] d,
                       input logic f, input logic r);
    @(negedge clk);
    reset            = rs;
    bus.fifo_empty_i = e;
    bus.fifo_rdata_i = d;
    bus.flush_i      = f;
    bus.ready_i      = r;
    #2;
  endtask

  // Advance one clock and apply the same cycle to the reference.
  task automatic adv();
    @(posedge clk);
    m_pop  = m_rready();
    m_xfer = (mq.size() > 0) && bus.ready_i;
    if (reset) begin
      mq.delete();
      mlast = 16'h0000;
    end else if (bus.flush_i) begin
      if (mq.size() > 0) mlast = mq[0];
      mq.delete();
    end else begin
      if (m_xfer) begin
        mlast = mq[0];
        void'(mq.pop_front());
      end
      if (m_pop) mq.push_back(bus.fifo_rdata_i);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'($urandom), 16'($urandom), 1'b0, 1'($urandom));
      n_chk++;
      if (bus.fifo_rready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_rready: got %b expected 0", bus.fifo_rready_o);
      end
      adv();
    end
    drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    n_chk++;
    if ({bus.valid_o, bus.data_o, bus.occupancy_o} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b data=%h occ=%0d expected 0/0000/0",
               bus.valid_o, bus.data_o, bus.occupancy_o);
    end
    adv();
  endtask

  task automatic test_first_pop();
    drive(1'b0, 1'b0, 16'h00A1, 1'b0, 1'b1);
    n_chk++;
    if (bus.fifo_rready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL first_pop_rready: got %b expected 1", bus.fifo_rready_o);
    end
    adv();
    drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);
    n_chk++;
    if (bus.valid_o !== 1'b1 || bus.data_o !== 16'h00A1) begin
      n_fail++;
      $display("FAIL first_pop_data: got valid=%b data=%h expected 1/00a1",
               bus.valid_o, bus.data_o);
    end
    adv();
    drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);
    n_chk++;
    if (bus.valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL first_pop_drain: got valid=%b expected 0", bus.valid_o);
    end
    adv();
  endtask

  task automatic test_backpressure();
    int idx;
    int exp;
    idx = 1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, idx > 8, 16'(idx), 1'b0, 1'b0);
      adv();
      if (m_pop) idx++;
    end
    drive(1'b0, idx > 8, 16'(idx), 1'b0, 1'b0);
    n_chk++;
    if (bus.occupancy_o !== 2'd2 || bus.fifo_rready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full: got occ=%0d rready=%b expected 2/0",
               bus.occupancy_o, bus.fifo_rready_o);
    end
    adv();
    if (m_pop) idx++;
    exp = 1;
    for (int c = 0; c < 20 && exp <= 8; c++) begin
      drive(1'b0, idx > 8, 16'(idx), 1'b0, 1'b1);
      n_chk++;
      if (bus.valid_o !== 1'b1 || bus.data_o !== 16'(exp)) begin
        n_fail++;
        $display("FAIL bp_stream: got valid=%b data=%h expected 1/%h",
                 bus.valid_o, bus.data_o, 16'(exp));
      end
      adv();
      exp++;
      if (m_pop) idx++;
    end
    n_chk++;
    if (exp <= 8) begin
      n_fail++;
      $display("FAIL bp_timeout: got %0d entries expected 8", exp - 1);
    end
    drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);
    n_chk++;
    if (bus.valid_o !== 1'b0 || bus.occupancy_o !== 2'd0) begin
      n_fail++;
      $display("FAIL bp_drain: got valid=%b occ=%0d expected 0/0",
               bus.valid_o, bus.occupancy_o);
    end
    adv();
  endtask

  task automatic test_flush();
    drive(1'b0, 1'b0, 16'h0011, 1'b0, 1'b0);
    adv();
    drive(1'b0, 1'b0, 16'h0022, 1'b0, 1'b0);
    adv();
    drive(1'b0, 1'b0, 16'h0033, 1'b1, 1'($urandom));
    n_chk++;
    if (bus.fifo_rready_o !== 1'b0 || bus.occupancy_o !== 2'd2 || bus.data_o !== 16'h0011) begin
      n_fail++;
      $display("FAIL flush_cycle: got rready=%b occ=%0d data=%h expected 0/2/0011",
               bus.fifo_rready_o, bus.occupancy_o, bus.data_o);
    end
    adv();
    drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    n_chk++;
    if (bus.valid_o !== 1'b0 || bus.occupancy_o !== 2'd0) begin
      n_fail++;
      $display("FAIL flush_after: got valid=%b occ=%0d expected 0/0",
               bus.valid_o, bus.occupancy_o);
    end
    adv();
  endtask

  task automatic test_empty_idle();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 16'($urandom), 1'b0, 1'(i));
      n_chk++;
      if (bus.fifo_rready_o !== 1'b0 || bus.valid_o !== 1'b0 || bus.occupancy_o !== 2'd0) begin
        n_fail++;
        $display("FAIL idle: got rready=%b valid=%b occ=%0d expected 0/0/0",
                 bus.fifo_rready_o, bus.valid_o, bus.occupancy_o);
      end
      adv();
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b0, 16'h0077, 1'b0, 1'b0);
    adv();
    drive(1'b0, 1'b0, 16'h0088, 1'b0, 1'b0);
    adv();
    drive(1'b1, 1'b0, 16'h0099, 1'b1, 1'b1);
    n_chk++;
    if (bus.fifo_rready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_rready: got %b expected 0", bus.fifo_rready_o);
    end
    adv();
    drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    n_chk++;
    if ({bus.valid_o, bus.data_o, bus.occupancy_o, bus.fifo_rready_o} !== 20'd0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got valid=%b data=%h occ=%0d rready=%b expected all 0",
               bus.valid_o, bus.data_o, bus.occupancy_o, bus.fifo_rready_o);
    end
    adv();
    drive(1'b0, 1'b0, 16'h0055, 1'b0, 1'b0);
    adv();
    drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);
    n_chk++;
    if (bus.valid_o !== 1'b1 || bus.data_o !== 16'h0055) begin
      n_fail++;
      $display("FAIL rst_mid_first: got valid=%b data=%h expected 1/0055",
               bus.valid_o, bus.data_o);
    end
    adv();
  endtask

  task automatic test_random();
    for (int i = 0; i < c_RAND_CYCLES; i++) begin
      drive($urandom_range(0, 99) < 2, ($urandom % 4) == 0, 16'($urandom),
            ($urandom % 20) == 0, ($urandom % 3) != 0);
      n_chk++;
      if (bus.fifo_rready_o !== m_rready() || bus.valid_o !== (mq.size() > 0) ||
          bus.occupancy_o !== 2'(mq.size()) || bus.data_o !== m_data()) begin
        n_fail++;
        $display("FAIL random[%0d]: got rready=%b valid=%b occ=%0d data=%h expected %b/%b/%0d/%h",
                 i, bus.fifo_rready_o, bus.valid_o, bus.occupancy_o, bus.data_o,
                 m_rready(), mq.size() > 0, mq.size(), m_data());
      end
      adv();
    end
  endtask

`ifdef FIFO_SKID_READER_STATS_EN
  task automatic test_stats();
    drive(1'b0, 1'b0, 16'h00C3, 1'b0, 1'b0);
    adv();
    drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    repeat (70000) @(posedge clk);
    #2;
    n_chk++;
    if (bus.valid_o !== 1'b1 || stall_cycles !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL stats_sat: got valid=%b count=%h expected 1/ffff",
               bus.valid_o, stall_cycles);
    end
    repeat (10) @(posedge clk);
    #2;
    n_chk++;
    if (stall_cycles !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL stats_hold: got %h expected ffff", stall_cycles);
    end
  endtask
`endif

  initial begin
    n_chk            = 0;
    n_fail           = 0;
    mlast            = 16'h0000;
    m_pop            = 1'b0;
    m_xfer           = 1'b0;
    reset            = 1'b1;
    bus.fifo_empty_i = 1'b1;
    bus.fifo_rdata_i = 16'h0000;
    bus.flush_i      = 1'b0;
    bus.ready_i      = 1'b0;
    test_reset();
    test_first_pop();
    test_backpressure();
    test_flush();
    test_empty_idle();
    test_reset_mid();
    test_random();
`ifdef FIFO_SKID_READER_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_skid_reader.md
FIFO_SKID_READER -- requirements
Module: fifo_skid_reader

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 16, giving the payload width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 fifo_rdata_i  input  DATA_WIDTH  head entry of upstream fifo_buffer; combinational, zero read latency.
REQ-005 fifo_empty_i  input  1  upstream FIFO empty flag.
REQ-006 fifo_rready_o  output  1  pop request to upstream FIFO; pop takes effect at the next clk edge.
REQ-007 flush_i  input  1  discard all buffered entries.
REQ-008 data_o  output  DATA_WIDTH  oldest buffered entry.
REQ-009 valid_o  output  1  data_o holds a valid entry.
REQ-010 ready_i  input  1  downstream accepts data_o when valid_o is high.
REQ-011 occupancy_o  output  2  number of buffered entries, 0..2.

Function
REQ-012 The module SHALL hold up to two entries: a main register driving data_o and a skid register.
REQ-013 The state SHALL be one of SKID_EMPTY (0 entries), SKID_ONE (1), SKID_FULL (2); occupancy_o SHALL equal the state's entry count.
REQ-014 fifo_rready_o SHALL equal ~fifo_empty_i & ~flush_i & (state != SKID_FULL), with no combinational path from ready_i.
REQ-015 A pop SHALL occur when fifo_rready_o is high; fifo_rdata_i SHALL be captured in that same cycle.
REQ-016 A transfer SHALL occur when valid_o & ready_i; valid_o SHALL equal (state != SKID_EMPTY).
REQ-017 Transitions:
- EMPTY + pop -> ONE, with the popped data in main.
- ONE + pop only -> FULL, with the popped data in skid.
- ONE + transfer only -> EMPTY.
- ONE + pop + transfer -> ONE, with the popped data in main.
- FULL + transfer -> ONE, with skid moved to main.
- No pop and no transfer -> hold all state.
REQ-018 Entries SHALL leave in strict FIFO order, with no duplication or loss.
REQ-019 Latency: a pop in cycle N SHALL make valid_o high in cycle N+1 when the module was empty.
REQ-020 Throughput: with upstream never empty and ready_i held high, one transfer SHALL occur per cycle.
REQ-021 flush_i SHALL force state to SKID_EMPTY at the next edge, overriding any pop or transfer in that cycle; a transfer coincident with flush_i is still counted as accepted downstream.
REQ-022 data_o SHALL hold its last value when valid_o is low.

Reset
REQ-023 When reset is high, the next edge SHALL set the state to SKID_EMPTY and zero the main and skid registers.
REQ-024 After that edge: valid_o=0, data_o=0, occupancy_o=0.
REQ-025 fifo_rready_o SHALL be 0 whenever reset is high, including reset asserted mid-operation; reset SHALL override flush_i.

Configuration
REQ-026 Macro FIFO_SKID_READER_STATS_EN, when defined, SHALL add output stall_cycles_o [15:0]:
- increments every cycle valid_o & ~ready_i;
- saturates at 16'hFFFF;
- cleared by reset;
- not cleared by flush_i.
REQ-027 Without FIFO_SKID_READER_STATS_EN, the port and its counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-028 The enum skid_state_e (SKID_EMPTY, SKID_ONE, SKID_FULL) SHALL reside in the shared package cpu_common_pkg.
REQ-029 The stall counter SHALL be a sub-module sat_counter (parameter WIDTH), instantiated only under FIFO_SKID_READER_STATS_EN.

Verification
REQ-030 Reset, then fifo_empty_i=0, fifo_rdata_i=16'h00A1, ready_i=1 -> fifo_rready_o=1, then the next cycle valid_o=1, data_o=16'h00A1.
REQ-031 Stream 16'h0001..16'h0008 with ready_i=0 after the first pop -> occupancy_o reaches 2, fifo_rready_o=0; on ready_i=1, data_o outputs 0001,0002,... in order with no gaps.
REQ-032 State FULL holding 16'h0011 and 16'h0022, then flush_i=1 for one cycle -> next cycle valid_o=0, occupancy_o=0, fifo_rready_o=0 during the flush cycle.
REQ-033 fifo_empty_i=1 continuously with ready_i toggling -> fifo_rready_o=0, valid_o=0, occupancy_o=0 throughout.
REQ-034 Reset asserted while in FULL -> next cycle all outputs at reset values, and the first subsequent pop's data is output first.
REQ-035 With FIFO_SKID_READER_STATS_EN defined: valid_o=1, ready_i=0 for 70000 cycles -> stall_cycles_o=16'hFFFF and holds there.
